// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: nominal 640x480 timing, lock FSM states and counter helpers shared by the frame decoder
package vga_timing_pkg;
  localparam int H_TOTAL_NOM  = 800;
  localparam int V_TOTAL_NOM  = 521;
  localparam int H_SYNC_NOM   = 96;
  localparam int H_START_NOM  = 144;
  localparam int V_START_NOM  = 31;
  localparam int H_ACTIVE_NOM = 640;
  localparam int V_ACTIVE_NOM = 480;
  localparam int SPLIT_COL    = 320;
  localparam int LOCK_FRAMES  = 2;
  localparam int CW           = 10;
  localparam logic [CW-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_t;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return v == CNT_MAX ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/vga_min_tracker.sv
// vga_min_tracker: N independent W-bit running minimums sharing one valid bit, cleared per frame
module vga_min_tracker #(
  parameter int N = 1,
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           smp,
  input  logic [N*W-1:0] val,
  output logic [N*W-1:0] vmin,
  output logic           vld
);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vmin <= '1;
      vld  <= 1'b0;
    end else if (smp) begin
      for (int i = 0; i < N; i++)
        if (val[i*W +: W] < vmin[i*W +: W]) vmin[i*W +: W] <= val[i*W +: W];
      vld <= 1'b1;
    end
  end
endmodule

// File: rtl/vga_frame_decoder.sv
// vga_frame_decoder: rebuilds VGA counters from sync edges, checks timing for lock,
// and reports per-frame ball and paddle positions.
module vga_frame_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_NOM,
  parameter int V_TOTAL  = V_TOTAL_NOM,
  parameter int H_SYNC   = H_SYNC_NOM,
  parameter int H_START  = H_START_NOM,
  parameter int V_START  = V_START_NOM,
  parameter int H_ACTIVE = H_ACTIVE_NOM,
  parameter int V_ACTIVE = V_ACTIVE_NOM,
  parameter int X_SPLIT  = SPLIT_COL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs,
  input  logic       vs,
  input  logic       r,
  input  logic       g,
  input  logic       b,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       active,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       sync_err,
  output logic       frame_done,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_valid,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic       pad_l_valid,
  output logic       pad_r_valid
);
  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] HSY = 10'(H_SYNC);
  localparam logic [9:0] HS0 = 10'(H_START);
  localparam logic [9:0] HE  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_START);
  localparam logic [9:0] VE  = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] XS  = 10'(X_SPLIT);
  logic hs_d1, hs_q, hs_qq, vs_d1, vs_q, vs_qq, r_d1, r_q, g_d1, g_q;
  logic hs_fall, hs_rise, vs_fall, act_cur, err_cur, h_seen, v_seen;
  logic [9:0] h_inc, v_inc, h_cur, v_cur, px_cur, py_cur, pl_mn, pr_mn;
  logic [19:0] red_mn;
  logic red_v, pl_v, pr_v, unused_b;
  lock_state_t state, state_n;
  logic [1:0] good_cnt, good_n;
  assign unused_b = b;
  // Sync history resets high so a released reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      {hs_d1, hs_q, hs_qq, vs_d1, vs_q, vs_qq} <= '1;
      {r_d1, r_q, g_d1, g_q} <= '0;
    end else begin
      {hs_d1, hs_q, hs_qq} <= {hs, hs_d1, hs_q};
      {vs_d1, vs_q, vs_qq} <= {vs, vs_d1, vs_q};
      {r_d1, r_q, g_d1, g_q} <= {r, r_d1, g, g_d1};
    end
  end
  // h_cur/v_cur are the coordinates of the sample currently at hs_q
  always_comb begin
    hs_fall = !hs_q && hs_qq;
    hs_rise = hs_q && !hs_qq;
    vs_fall = !vs_q && vs_qq;
    h_inc   = sat_inc(h_count);
    v_inc   = sat_inc(v_count);
    h_cur   = hs_fall ? '0 : h_inc;
    v_cur   = vs_fall ? '0 : hs_fall ? v_inc : v_count;
    act_cur = h_cur >= HS0 && h_cur < HE && v_cur >= VS0 && v_cur < VE;
    px_cur  = act_cur ? h_cur - HS0 : '0;
    py_cur  = act_cur ? v_cur - VS0 : '0;
    err_cur = (hs_fall && h_seen && h_inc != HT) ||
              (hs_rise && h_seen && h_cur != HSY) ||
              (vs_fall && v_seen && v_inc != VT) ||
              (h_cur == CNT_MAX && h_count != CNT_MAX) ||
              (v_cur == CNT_MAX && v_count != CNT_MAX);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {h_count, v_count, pix_x, pix_y, line_len, frame_lines} <= '0;
      {active, sync_err, frame_done, h_seen, v_seen} <= '0;
      {ball_x, ball_y, pad_l_y, pad_r_y} <= '0;
      {ball_valid, pad_l_valid, pad_r_valid} <= '0;
    end else begin
      h_count    <= h_cur;
      v_count    <= v_cur;
      active     <= act_cur;
      pix_x      <= px_cur;
      pix_y      <= py_cur;
      sync_err   <= err_cur;
      frame_done <= vs_fall;
      if (hs_fall) begin
        line_len <= h_inc;
        h_seen   <= 1'b1;
      end
      if (vs_fall) begin
        frame_lines <= v_inc;
        v_seen      <= 1'b1;
        ball_x      <= red_v ? red_mn[9:0] : '0;
        ball_y      <= red_v ? red_mn[19:10] : '0;
        ball_valid  <= red_v;
        pad_l_y     <= pl_v ? pl_mn : '0;
        pad_l_valid <= pl_v;
        pad_r_y     <= pr_v ? pr_mn : '0;
        pad_r_valid <= pr_v;
      end
    end
  end
  vga_min_tracker #(.N(2), .W(10)) u_red (
    .clk(clk), .reset(reset), .clr(vs_fall), .smp(act_cur && r_q),
    .val({py_cur, px_cur}), .vmin(red_mn), .vld(red_v)
  );
  vga_min_tracker #(.N(1), .W(10)) u_pad_l (
    .clk(clk), .reset(reset), .clr(vs_fall), .smp(act_cur && g_q && px_cur < XS),
    .val(py_cur), .vmin(pl_mn), .vld(pl_v)
  );
  vga_min_tracker #(.N(1), .W(10)) u_pad_r (
    .clk(clk), .reset(reset), .clr(vs_fall), .smp(act_cur && g_q && px_cur >= XS),
    .val(py_cur), .vmin(pr_mn), .vld(pr_v)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
    end
  end
  // A frame reaching frame_done in ACQUIRE was error-free, since any error leaves ACQUIRE
  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    case (state)
      UNLOCKED: if (frame_done) begin
        state_n = ACQUIRE;
        good_n  = '0;
      end
      ACQUIRE: if (sync_err) state_n = UNLOCKED;
        else if (frame_done) begin
          good_n  = good_cnt + 2'd1;
          state_n = good_cnt == 2'(LOCK_FRAMES - 1) ? LOCKED : ACQUIRE;
        end
      LOCKED: if (sync_err) state_n = UNLOCKED;
      default: state_n = UNLOCKED;
    endcase
  end
  always_comb locked = state == LOCKED;
endmodule

// File: tb/tb_vga_frame_decoder.sv
// tb_vga_frame_decoder: directed checks of the decoder against a scaled-down VGA generator model
module tb_vga_frame_decoder;
  // Scaled timing keeps a frame at 800 clocks
  localparam int HT = 40, HSY = 6, HS0 = 10, HA = 24, VT = 20, VS0 = 4, VA = 12, XSP = 12, VSW = 2;
  localparam int BX = 15, BY = 7, PLX = 10, PLY = 2, PRX = 12, PRY = 8;
  logic clk = 1'b0, reset = 1'b1, hs = 1'b1, vs = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0;
  logic [9:0] h_count, v_count, pix_x, pix_y, line_len, frame_lines, ball_x, ball_y, pad_l_y, pad_r_y;
  logic active, locked, sync_err, frame_done, ball_valid, pad_l_valid, pad_r_valid;
  logic [106:0] outs;
  int vecs = 0, bad = 0;
  int gh = 20, gv = 10, h0 = -1, h1 = -1, h2 = -1, v0 = -1, v1 = -1, v2 = -1;
  int err_cnt = 0, cyc = 0, last_fd = 0, per = 0, held = 0;
  bit hs_hold = 0, short_now = 0, red_on = 1, white = 0;
  int wh[6] = '{HS0 - 1, HS0, HS0 + HA - 1, HS0 + HA, HS0 + 2, HS0 + 2};
  int wv[6] = '{VS0 + 3, VS0 + 3, VS0 + 3, VS0 + 3, VS0 + VA - 1, VS0 + VA};

  vga_frame_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HSY), .H_START(HS0), .V_START(VS0),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .X_SPLIT(XSP)
  ) dut (
    .clk(clk), .reset(reset), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .h_count(h_count), .v_count(v_count), .active(active), .pix_x(pix_x), .pix_y(pix_y),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked), .sync_err(sync_err),
    .frame_done(frame_done), .ball_x(ball_x), .ball_y(ball_y), .ball_valid(ball_valid),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .pad_l_valid(pad_l_valid), .pad_r_valid(pad_r_valid)
  );

  assign outs = {h_count, v_count, active, pix_x, pix_y, line_len, frame_lines, locked, sync_err,
                 frame_done, ball_x, ball_y, ball_valid, pad_l_y, pad_r_y, pad_l_valid, pad_r_valid};

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pixel of the generator model, clock it, then advance the raster position
  task automatic step();
    int x, y;
    bit act, pr, pg;
    x   = gh - HS0;
    y   = gv - VS0;
    act = gh >= HS0 && gh < HS0 + HA && gv >= VS0 && gv < VS0 + VA;
    pr  = red_on && x >= BX && x < BX + 3 && y >= BY && y < BY + 3;
    pg  = (x >= PLX && x < PLX + 2 && y >= PLY && y < PLY + 4) ||
          (x >= PRX && x < PRX + 2 && y >= PRY && y < PRY + 4) || (white && pr);
    hs  = hs_hold || gh >= HSY;
    vs  = gv >= VSW;
    r   = act && pr;
    g   = act && pg;
    b   = act;
    h2 = h1; h1 = h0; h0 = gh;
    v2 = v1; v1 = v0; v0 = gv;
    @(posedge clk);
    #1;
    cyc++;
    if (sync_err) err_cnt++;
    if (gh == (short_now ? HT - 2 : HT - 1)) begin
      gh = 0;
      short_now = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else gh++;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 2 * HT * VT);
    chk(tag, frame_done, 1'b1);
    per = cyc - last_fd;
    last_fd = cyc;
  endtask

  // h2/v2 hold the raster position driven two clocks back, which the counters must show now
  task automatic until_at(input int h, input int v, input string tag);
    int n;
    logic a;
    n = 0;
    do begin
      step();
      n++;
    end while (!(h2 == h && v2 == v) && n < 2 * HT * VT);
    a = h >= HS0 && h < HS0 + HA && v >= VS0 && v < VS0 + VA;
    chk(tag, {h_count, v_count, active, pix_x, pix_y},
        {10'(h), 10'(v), a, a ? 10'(h - HS0) : 10'd0, a ? 10'(v - VS0) : 10'd0});
  endtask

  initial begin
    repeat (4) step();
    chk("rst_all", outs, '0);
    reset = 1'b0;
    err_cnt = 0;
    wait_fd("fd1");
    chk("fd1_lock", locked, 1'b0);
    wait_fd("fd2");
    chk("fd2_ball", {ball_valid, ball_x, ball_y}, {1'b1, 10'd15, 10'd7});
    chk("fd2_pad", {pad_l_valid, pad_l_y, pad_r_valid, pad_r_y}, {1'b1, 10'd2, 1'b1, 10'd8});
    chk("fd2_len", {line_len, frame_lines}, {10'd40, 10'd20});
    chk("fd2_lock", locked, 1'b0);
    chk("fd2_period", per, HT * VT);
    wait_fd("fd3");
    chk("fd3_pre", locked, 1'b0);
    step();
    chk("fd3_lock", locked, 1'b1);
    chk("fd_pulse", frame_done, 1'b0);
    chk("clean", err_cnt, 0);
    for (int i = 0; i < 6; i++) until_at(wh[i], wv[i], $sformatf("win%0d", i));
    for (int n = 0; n < 2 * HT * VT && !(gh == 0 && gv == 8); n++) step();
    short_now = 1;
    for (int n = 0; n < 4 * HT && !sync_err; n++) step();
    chk("short_err", sync_err, 1'b1);
    chk("short_len", line_len, 10'd39);
    chk("short_hold", locked, 1'b1);
    step();
    chk("short_unlock", locked, 1'b0);
    err_cnt = 0;
    wait_fd("re1");
    wait_fd("re2");
    wait_fd("re3");
    chk("re_pre", locked, 1'b0);
    step();
    chk("relock", locked, 1'b1);
    chk("re_clean", err_cnt, 0);
    white = 1;
    wait_fd("wht");
    white = 0;
    chk("wht_pad", {pad_r_valid, pad_r_y, pad_l_y}, {1'b1, 10'd7, 10'd2});
    chk("wht_ball", {ball_x, ball_y}, {10'd15, 10'd7});
    red_on = 0;
    wait_fd("nored");
    red_on = 1;
    chk("nored_ball", {ball_valid, ball_x, ball_y}, '0);
    chk("nored_pad", {pad_l_valid, pad_l_y, pad_r_valid, pad_r_y}, {1'b1, 10'd2, 1'b1, 10'd8});
    chk("nored_lock", locked, 1'b1);
    for (int n = 0; n < HT && gh != HSY + 1; n++) step();
    hs_hold = 1;
    held = 0;
    for (int n = 0; n < 1100 && h_count != 10'h3ff; n++) begin
      step();
      held++;
    end
    chk("sat_err", sync_err, 1'b1);
    chk("sat_h", h_count, 10'h3ff);
    step();
    held++;
    chk("sat_hold", h_count, 10'h3ff);
    chk("sat_unlock", locked, 1'b0);
    while (held < 1100 || gh != HSY + 1) begin
      step();
      held++;
    end
    hs_hold = 0;
    wait_fd("post1");
    wait_fd("post2");
    chk("post_ball", {ball_valid, ball_x, ball_y}, {1'b1, 10'd15, 10'd7});
    for (int n = 0; n < 2 * HT * VT && !(h_count == 10'd25 && v_count == 10'd15); n++) step();
    chk("rst_pt", {h_count, v_count}, {10'd25, 10'd15});
    reset = 1'b1;
    step();
    chk("mid_rst", outs, '0);
    reset = 1'b0;
    err_cnt = 0;
    repeat (5) step();
    chk("rst_rel", {h_count, v_count, sync_err}, {10'd5, 10'd0, 1'b0});
    wait_fd("ar1");
    wait_fd("ar2");
    wait_fd("ar3");
    chk("ar_pre", locked, 1'b0);
    step();
    chk("ar_lock", locked, 1'b1);
    chk("ar_clean", err_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
